program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Generates the 8-bit program-memory address that fetches each instruction.
- The fetched instruction is decoded into the computational unit's control signals (source_sel, reg_en, x_sel/y_sel/i_sel, nibble_ir); this block sits directly upstream of that decode/execute path.
- Supports:
  - sequential increment,
  - unconditional page jump,
  - conditional jump on the computational unit's zero flag,
  - a counted-loop instruction driven by an internal loop counter,
  - pipeline hold.
- An optional return-address stack adds call/return.

Parameters:
- AW, 8: program-memory address width.
- LCW, 4: loop-counter width; matches the data_bus nibble.
- STACK_DEPTH, 4: return-stack entries. Used only when the optional feature is compiled in.

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- hold, input, 1: freezes all state for this cycle.
- jmp, input, 1: unconditional jump request.
- jmp_nz, input, 1: jump if r_eq_0 == 0.
- r_eq_0, input, 1: zero flag from the computational unit.
- jmp_addr, input, 4: jump target low nibble (instruction bits [3:0]).
- lc_load, input, 1: load the loop counter from lc_data.
- lc_data, input, LCW: loop-counter load value (data_bus).
- loop, input, 1: counted-loop branch request.
- call, input, 1: subroutine call request. Ignored when the feature is out.
- ret, input, 1: subroutine return request. Ignored when the feature is out.
- pm_addr, output, AW: registered program-memory address.
- lc, output, LCW: registered loop-counter value.
- stack_depth, output, 3: current return-stack occupancy.
- stack_err, output, 1: sticky stack overflow/underflow flag.

Behaviour:
- **Reset.** reset_n low asynchronously forces pm_addr=0, lc=0, stack_depth=0, stack_err=0 and clears the stack contents. Reset asserted mid-operation aborts everything; the first fetch after release is from address 0.
- **Latency.** A request sampled at edge n determines pm_addr after edge n; requests are single-cycle strobes. pm_addr is the only address source; there is no combinational bypass.
- **Jump target.** target = {pm_addr[AW-1:4], jmp_addr}, i.e. a page-relative jump within the current 16-word page.
- **Increment.** Increment wraps from 8'hFF to 8'h00 with no flag.
- **Next-address priority** (highest first):
  1. hold: pm_addr, lc and the stack all hold; every other input is ignored, including lc_load.
  2. ret (feature in):
     - stack non-empty: pm_addr = top of stack, depth-1.
     - stack empty: stack_err=1, pm_addr+1.
  3. call (feature in):
     - depth < STACK_DEPTH: push pm_addr+1, pm_addr = target, depth+1.
     - stack full: stack_err=1, no push, pm_addr+1.
  4. jmp: pm_addr = target.
  5. jmp_nz: r_eq_0==0 gives pm_addr = target; otherwise pm_addr+1.
  6. loop:
     - lc != 0: lc = lc-1 and pm_addr = target.
     - lc == 0: pm_addr+1, lc stays 0.
  7. None of the above: pm_addr+1.
- **Loop counter.**
  - lc_load (without hold) sets lc = lc_data and overrides any loop decrement that cycle.
  - The loop branch decision always uses the pre-edge lc.
  - lc_load=1 with lc_data=N followed by N+1 loop strobes yields N taken branches then a fall-through.
- **Simultaneous requests.** Multiple requests in the same cycle are legal and resolved strictly by the priority above; lower-priority requests are discarded. Exception: lc_load is independent of the address priority and is blocked only by hold.
- **stack_err.** Sticky; cleared only by reset.
- **r_eq_0.** Sampled with no synchronisation; it is in the same clock domain.

Optional Feature:
- Macro: PROGRAM_SEQUENCER_CALL_STACK_EN.
- Defined: STACK_DEPTH x AW return stack; call/ret behave as above; stack_depth and stack_err are live.
- Undefined: no stack storage. call and ret are ignored, and a cycle with only call/ret asserted behaves as a plain increment. stack_depth is tied to 0 and stack_err is tied to 0. Ports remain present so the interface is unchanged.

Test Plan:
1. **Reset and wrap.** Release reset_n with no requests for 258 cycles -> pm_addr counts 0..FF, then 00, 01. Assert reset_n low mid-count at pm_addr=8'h37 -> pm_addr=0 immediately, before the next clk edge.
2. **Page jumps.** At pm_addr=8'h5A assert jmp, jmp_addr=4'h3 -> next pm_addr=8'h53. At 8'h20 assert jmp_nz with r_eq_0=1 -> 8'h21. Repeat with r_eq_0=0 and jmp_addr=4'hC -> 8'h2C.
3. **Counted loop.** lc_load with lc_data=3, then loop with jmp_addr=4'h0 each time execution reaches the loop instruction -> three taken branches (lc=2,1,0), fourth loop falls through. lc_load and loop in the same cycle -> lc=lc_data and the branch follows the old lc.
4. **Hold precedence.** hold=1 together with jmp, lc_load=1 and lc_data=7 for 3 cycles -> pm_addr and lc unchanged. Release hold -> increment resumes from the frozen address.
5. **Stack, feature in.** Nested calls from 8'h10, 8'h41, 8'h72, 8'hA3 -> depth=4; a fifth call -> stack_err=1, no jump, pm_addr+1. Four rets -> returns to A4, 73, 42, 11. A fifth ret -> stack_err stays 1, pm_addr+1.
6. **Stack, feature out.** Macro undefined: call at 8'h10 -> pm_addr=8'h11; stack_depth=0 and stack_err=0 throughout.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: program-memory address generator (page jumps, counted loop, hold); call/ret stack when PROGRAM_SEQUENCER_CALL_STACK_EN is defined
module program_sequencer #(
  parameter int AW = 8,
  parameter int LCW = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           hold,
  input  logic           jmp,
  input  logic           jmp_nz,
  input  logic           r_eq_0,
  input  logic [3:0]     jmp_addr,
  input  logic           lc_load,
  input  logic [LCW-1:0] lc_data,
  input  logic           loop,
  input  logic           call,
  input  logic           ret,
  output logic [AW-1:0]  pm_addr,
  output logic [LCW-1:0] lc,
  output logic [2:0]     stack_depth,
  output logic           stack_err
);
  logic [AW-1:0] inc, target, seq_next, pm_next;
  logic lc_nz, stack_busy, loop_dec;
  assign inc = pm_addr + AW'(1);
  assign target = {pm_addr[AW-1:4], jmp_addr};
  assign lc_nz = |lc;
  assign seq_next = jmp ? target : jmp_nz ? (r_eq_0 ? inc : target) : (loop && lc_nz) ? target : inc;
  assign loop_dec = loop && lc_nz && !jmp && !jmp_nz && !stack_busy;
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
  localparam int SW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
  logic [AW-1:0] stk [STACK_DEPTH];
  logic empty, full;
  assign empty = stack_depth == 3'd0;
  assign full = stack_depth >= 3'(STACK_DEPTH);
  assign stack_busy = call | ret;
  assign pm_next = ret ? (empty ? inc : stk[SW'(stack_depth - 3'd1)]) : call ? (full ? inc : target) : seq_next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stack_depth <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
    end else if (!hold) begin
      if (ret) begin
        if (empty) stack_err <= 1'b1;
        else stack_depth <= stack_depth - 3'd1;
      end else if (call) begin
        if (full) stack_err <= 1'b1;
        else begin
          stk[SW'(stack_depth)] <= inc;
          stack_depth <= stack_depth + 3'd1;
        end
      end
    end
`else
  logic unused_stack;
  assign unused_stack = &{1'b0, call, ret, 32'(STACK_DEPTH)};
  assign stack_busy = 1'b0;
  assign pm_next = seq_next;
  assign stack_depth = '0;
  assign stack_err = 1'b0;
`endif
  // lc_load overrides the loop decrement; the branch decision already used the old lc
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pm_addr <= '0;
      lc <= '0;
    end else if (!hold) begin
      pm_addr <= pm_next;
      lc <= lc_load ? lc_data : loop_dec ? lc - LCW'(1) : lc;
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: vector table plus hand sequences, expectations queued at drive time and compared after each edge
module tb_program_sequencer;
  logic clk = 1'b0;
  logic reset_n, hold, jmp, jmp_nz, r_eq_0, lc_load, loop, call, ret;
  logic [3:0] jmp_addr, lc_data, lc;
  logic [7:0] pm_addr;
  logic [2:0] stack_depth;
  logic stack_err;

  typedef struct packed {
    logic hold, jmp, jmp_nz, r_eq_0;
    logic [3:0] ja;
    logic lc_load;
    logic [3:0] ld;
    logic loop, call, ret;
  } in_t;
  typedef struct {in_t i; logic [7:0] pm; logic [3:0] lc;} vec_t;
  typedef struct {string name; logic [7:0] pm; logic [3:0] lc; logic [2:0] dep; logic err;} exp_t;

  exp_t sb[$];
  vec_t tbl[25];
  int total = 0, passed = 0;
  logic [7:0] cur_pm;
  logic [3:0] cur_lc;
  logic [2:0] cur_dep;
  logic cur_err;
  localparam in_t IDLE = '0;

  program_sequencer dut (
    .clk(clk), .reset_n(reset_n), .hold(hold), .jmp(jmp), .jmp_nz(jmp_nz),
    .r_eq_0(r_eq_0), .jmp_addr(jmp_addr), .lc_load(lc_load), .lc_data(lc_data),
    .loop(loop), .call(call), .ret(ret), .pm_addr(pm_addr), .lc(lc),
    .stack_depth(stack_depth), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic h, j, jn, r, input logic [3:0] ja,
                             input logic ll, input logic [3:0] ld, input logic lp, c, rt);
    return {h, j, jn, r, ja, ll, ld, lp, c, rt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply(input in_t v);
    {hold, jmp, jmp_nz, r_eq_0, jmp_addr, lc_load, lc_data, loop, call, ret} = v;
  endtask

  task automatic step(input string name, input in_t v, input logic [7:0] epm,
                      input logic [3:0] elc, input logic [2:0] ed, input logic ee);
    exp_t e;
    apply(v);
    sb.push_back('{name, epm, elc, ed, ee});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, " pm_addr"}, 32'(pm_addr), 32'(e.pm));
    check({e.name, " lc"}, 32'(lc), 32'(e.lc));
    check({e.name, " stack_depth"}, 32'(stack_depth), 32'(e.dep));
    check({e.name, " stack_err"}, 32'(stack_err), 32'(e.err));
    cur_pm = epm;
    cur_lc = elc;
    cur_dep = ed;
    cur_err = ee;
  endtask

  task automatic idle(input string name);
    step(name, IDLE, cur_pm + 8'd1, cur_lc, cur_dep, cur_err);
  endtask

  task automatic advance_to(input logic [7:0] a);
    while (cur_pm != a) idle("advance");
  endtask

  task automatic do_reset(input string name);
    apply(IDLE);
    #2 reset_n = 1'b0;
    #1;
    check({name, " pm_addr"}, 32'(pm_addr), 32'h0);
    check({name, " lc"}, 32'(lc), 32'h0);
    check({name, " stack_depth"}, 32'(stack_depth), 32'h0);
    check({name, " stack_err"}, 32'(stack_err), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cur_pm = '0;
    cur_lc = '0;
    cur_dep = '0;
    cur_err = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{IDLE,                                8'h01, 4'd0};
    tbl[1]  = '{mk(0,1,0,0,4'h9,0,4'h0,0,0,0),       8'h09, 4'd0};
    tbl[2]  = '{mk(0,0,1,0,4'h2,0,4'h0,0,0,0),       8'h02, 4'd0};
    tbl[3]  = '{mk(0,0,1,1,4'hF,0,4'h0,0,0,0),       8'h03, 4'd0};
    tbl[4]  = '{mk(0,0,0,0,4'h0,1,4'h3,0,0,0),       8'h04, 4'd3};
    tbl[5]  = '{mk(0,0,0,0,4'h0,0,4'h0,1,0,0),       8'h00, 4'd2};
    tbl[6]  = '{IDLE,                                8'h01, 4'd2};
    tbl[7]  = '{mk(0,0,0,0,4'h0,0,4'h0,1,0,0),       8'h00, 4'd1};
    tbl[8]  = '{IDLE,                                8'h01, 4'd1};
    tbl[9]  = '{mk(0,0,0,0,4'h0,0,4'h0,1,0,0),       8'h00, 4'd0};
    tbl[10] = '{IDLE,                                8'h01, 4'd0};
    tbl[11] = '{mk(0,0,0,0,4'h0,0,4'h0,1,0,0),       8'h02, 4'd0};
    tbl[12] = '{mk(0,0,0,0,4'h8,1,4'h5,1,0,0),       8'h03, 4'd5};
    tbl[13] = '{mk(0,0,0,0,4'h8,1,4'h2,1,0,0),       8'h08, 4'd2};
    tbl[14] = '{mk(0,1,0,0,4'h1,0,4'h0,1,0,0),       8'h01, 4'd2};
    tbl[15] = '{mk(0,0,1,1,4'h6,0,4'h0,1,0,0),       8'h02, 4'd2};
    tbl[16] = '{mk(0,1,1,1,4'hA,0,4'h0,0,0,0),       8'h0A, 4'd2};
    tbl[17] = '{mk(1,1,0,0,4'h0,1,4'h7,0,0,0),       8'h0A, 4'd2};
    tbl[18] = '{mk(1,1,0,0,4'h0,1,4'h7,0,0,0),       8'h0A, 4'd2};
    tbl[19] = '{mk(1,1,0,0,4'h0,1,4'h7,0,0,0),       8'h0A, 4'd2};
    tbl[20] = '{IDLE,                                8'h0B, 4'd2};
    tbl[21] = '{mk(0,0,0,0,4'hE,0,4'h0,1,0,0),       8'h0E, 4'd1};
    tbl[22] = '{IDLE,                                8'h0F, 4'd1};
    tbl[23] = '{IDLE,                                8'h10, 4'd1};
    tbl[24] = '{mk(0,1,0,0,4'h4,0,4'h0,0,0,0),       8'h14, 4'd1};

    reset_n = 1'b0;
    apply(IDLE);
    do_reset("reset");

    for (int k = 0; k < 258; k++) idle("wrap");
    advance_to(8'h35);
    step("lc_pre_reset", mk(0,0,0,0,4'h0,1,4'h9,0,0,0), 8'h36, 4'd9, 3'd0, 1'b0);
    idle("to_37");
    do_reset("mid_reset");

    for (int k = 0; k < 25; k++)
      step($sformatf("vec%0d", k), tbl[k].i, tbl[k].pm, tbl[k].lc, cur_dep, cur_err);

    advance_to(8'h5A);
    step("jmp_5a", mk(0,1,0,0,4'h3,0,4'h0,0,0,0), 8'h53, cur_lc, cur_dep, cur_err);
    advance_to(8'h20);
    step("jnz_zero", mk(0,0,1,1,4'hC,0,4'h0,0,0,0), 8'h21, cur_lc, cur_dep, cur_err);
    step("jnz_nonzero", mk(0,0,1,0,4'hC,0,4'h0,0,0,0), 8'h2C, cur_lc, cur_dep, cur_err);

    do_reset("stack_reset");
    advance_to(8'h10);
`ifdef PROGRAM_SEQUENCER_CALL_STACK_EN
    step("call1", mk(0,0,0,0,4'hF,0,4'h0,0,1,0), 8'h1F, 4'd0, 3'd1, 1'b0);
    advance_to(8'h41);
    step("call2", mk(0,0,0,0,4'h0,0,4'h0,0,1,0), 8'h40, 4'd0, 3'd2, 1'b0);
    advance_to(8'h72);
    step("call3", mk(0,0,0,0,4'h0,0,4'h0,0,1,0), 8'h70, 4'd0, 3'd3, 1'b0);
    advance_to(8'hA3);
    step("call4", mk(0,0,0,0,4'h0,0,4'h0,0,1,0), 8'hA0, 4'd0, 3'd4, 1'b0);
    step("call_full", mk(0,0,0,0,4'h5,0,4'h0,0,1,0), 8'hA1, 4'd0, 3'd4, 1'b1);
    step("hold_ret", mk(1,0,0,0,4'h0,0,4'h0,0,0,1), 8'hA1, 4'd0, 3'd4, 1'b1);
    step("ret1", mk(0,0,0,0,4'h0,0,4'h0,0,0,1), 8'hA4, 4'd0, 3'd3, 1'b1);
    step("ret2", mk(0,0,0,0,4'h0,0,4'h0,0,0,1), 8'h73, 4'd0, 3'd2, 1'b1);
    step("ret3", mk(0,0,0,0,4'h0,0,4'h0,0,0,1), 8'h42, 4'd0, 3'd1, 1'b1);
    step("ret4", mk(0,0,0,0,4'h0,0,4'h0,0,0,1), 8'h11, 4'd0, 3'd0, 1'b1);
    step("ret_empty", mk(0,0,0,0,4'h0,0,4'h0,0,0,1), 8'h12, 4'd0, 3'd0, 1'b1);
    step("ret_over_jmp", mk(0,1,0,0,4'h7,0,4'h0,0,0,1), 8'h13, 4'd0, 3'd0, 1'b1);
`else
    step("call_off", mk(0,0,0,0,4'h5,0,4'h0,0,1,0), 8'h11, 4'd0, 3'd0, 1'b0);
    step("ret_off", mk(0,0,0,0,4'h5,0,4'h0,0,0,1), 8'h12, 4'd0, 3'd0, 1'b0);
    step("call_ret_off", mk(0,0,0,0,4'h5,0,4'h0,0,1,1), 8'h13, 4'd0, 3'd0, 1'b0);
    step("call_jmp_off", mk(0,1,0,0,4'h7,0,4'h0,0,1,0), 8'h17, 4'd0, 3'd0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
